// File: rtl/netrxfifo.sv
// Store-and-forward receive FIFO: buffers abortable packets, rolls back aborted or
// overflowing ones, and forwards only complete packets. NETRXFIFO_DROPCOUNT_EN enables o_drops.
module netrxfifo #(
    parameter int DW     = 32,
    parameter int LGFLEN = 10
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              S_AXIN_VALID,
    output logic              S_AXIN_READY,
    input  logic [DW-1:0]     S_AXIN_DATA,
    input  logic              S_AXIN_LAST,
    input  logic              S_AXIN_ABORT,
    output logic              M_AXIN_VALID,
    input  logic              M_AXIN_READY,
    output logic [DW-1:0]     M_AXIN_DATA,
    output logic              M_AXIN_LAST,
    output logic              M_AXIN_ABORT,
    output logic [LGFLEN:0]   o_fill,
    output logic [15:0]       o_drops,
    output logic [1:0]        o_dbg_state,
    output logic              o_dbg_drop
);
    // Handshake: a word moves when VALID && READY at a rising edge; the output holds
    // DATA/LAST stable while VALID is high and READY low. The input side never stalls.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    localparam int PW = LGFLEN + 1;
    localparam logic [LGFLEN:0] DEPTH   = PW'(1 << LGFLEN);
    localparam logic [LGFLEN:0] PTR_ONE = PW'(1);

    logic [DW:0]     mem_q [0:(1<<LGFLEN)-1];
    state_e          state_q, state_d;
    logic [LGFLEN:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN:0] commit_q, commit_d;
    logic [LGFLEN:0] rd_ptr_q;
    logic [LGFLEN:0] fill_q;
    logic            ovalid_q;
    logic [DW-1:0]   odata_q;
    logic            olast_q;
    logic            mem_we;
    logic            drop;
    logic            full;
    logic            load;
    logic [DW:0]     rd_word;

    assign full = (wr_ptr_q - rd_ptr_q) == DEPTH;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        commit_d = commit_q;
        mem_we   = 1'b0;
        drop     = 1'b0;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (state_q == ST_WRITE && S_AXIN_ABORT) begin
                    wr_ptr_d = commit_q;
                    drop     = 1'b1;
                    state_d  = ST_IDLE;
                end else if (S_AXIN_VALID && S_AXIN_ABORT) begin
                    // Single-word abort at a packet boundary: nothing was written yet.
                    drop = 1'b1;
                end else if (S_AXIN_VALID) begin
                    if (full) begin
                        wr_ptr_d = commit_q;
                        drop     = 1'b1;
                        state_d  = S_AXIN_LAST ? ST_IDLE : ST_DROP;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (S_AXIN_LAST) begin
                            commit_d = wr_ptr_q + PTR_ONE;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (S_AXIN_ABORT || (S_AXIN_VALID && S_AXIN_LAST)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            commit_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            commit_q <= commit_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[wr_ptr_q[LGFLEN-1:0]] <= {S_AXIN_LAST, S_AXIN_DATA};
    end

    // Only committed entries are read, so the read never races the write slot.
    assign rd_word = mem_q[rd_ptr_q[LGFLEN-1:0]];
    assign load    = (commit_q != rd_ptr_q) && (!ovalid_q || M_AXIN_READY);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr_q <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            fill_q   <= '0;
        end else begin
            fill_q <= commit_q - rd_ptr_q;
            if (load) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                ovalid_q <= 1'b1;
                odata_q  <= rd_word[DW-1:0];
                olast_q  <= rd_word[DW];
            end else if (M_AXIN_READY) begin
                ovalid_q <= 1'b0;
            end
        end
    end

`ifdef NETRXFIFO_DROPCOUNT_EN
    logic [15:0] drops_q;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            drops_q <= '0;
        end else if (drop && drops_q != 16'hFFFF) begin
            drops_q <= drops_q + 16'd1;
        end
    end
    assign o_drops = drops_q;
`else
    assign o_drops = 16'd0;
`endif

    assign S_AXIN_READY = 1'b1;
    assign M_AXIN_ABORT = 1'b0;
    assign M_AXIN_VALID = ovalid_q;
    assign M_AXIN_DATA  = odata_q;
    assign M_AXIN_LAST  = olast_q;
    assign o_fill       = fill_q;
    assign o_dbg_state  = state_q;
    assign o_dbg_drop   = drop;
endmodule

// File: tb/tb_netrxfifo.sv
// Bench for netrxfifo: directed scenarios plus randomized packets, checked against a
// packet-level model (pending packet, committed word queue, drop count).
module tb_netrxfifo;
    localparam int DW     = 32;
    localparam int LGFLEN = 4;
    localparam int DEPTH  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic            s_last = 1'b0;
    logic            s_abort = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic            m_abort;
    logic [LGFLEN:0] fill;
    logic [15:0]     drops;
    logic [1:0]      dbg_state;
    logic            dbg_drop;

    always #5 clk = ~clk;

    netrxfifo #(.DW(DW), .LGFLEN(LGFLEN)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .S_AXIN_VALID(s_valid), .S_AXIN_READY(s_ready), .S_AXIN_DATA(s_data),
        .S_AXIN_LAST(s_last), .S_AXIN_ABORT(s_abort),
        .M_AXIN_VALID(m_valid), .M_AXIN_READY(m_ready), .M_AXIN_DATA(m_data),
        .M_AXIN_LAST(m_last), .M_AXIN_ABORT(m_abort),
        .o_fill(fill), .o_drops(drops), .o_dbg_state(dbg_state), .o_dbg_drop(dbg_drop)
    );

    int          tests = 0;
    int          fails = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] pkt_q[$];
    bit          dropping = 1'b0;
    int          model_drops = 0;
    bit          toggle_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] drops_exp();
`ifdef NETRXFIFO_DROPCOUNT_EN
        return (model_drops > 65535) ? 16'hFFFF : model_drops[15:0];
`else
        return 16'd0;
`endif
    endfunction

    // Packet-level reference: a packet reaches exp_q only when its LAST arrives intact.
    task automatic model(input bit v, input logic [DW-1:0] d, input bit l, input bit a);
        if (a) begin
            if (pkt_q.size() > 0 || (v && !dropping)) model_drops++;
            pkt_q.delete();
            dropping = 1'b0;
        end else if (v) begin
            if (dropping) begin
                if (l) dropping = 1'b0;
            end else if (exp_q.size() + pkt_q.size() >= DEPTH) begin
                model_drops++;
                pkt_q.delete();
                dropping = !l;
            end else begin
                pkt_q.push_back({l, d});
                if (l) begin
                    foreach (pkt_q[k]) exp_q.push_back(pkt_q[k]);
                    pkt_q.delete();
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_rdy) m_ready = ~m_ready;
    endtask

    task automatic send(input bit v, input logic [DW-1:0] d, input bit l, input bit a);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        s_abort = a;
        model(v, d, l, a);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_abort = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) send(1'b1, base + 32'(i), i == n - 1, 1'b0);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            tick();
            guard++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: sampled at the falling edge, between active edges.
    logic [DW:0] prev_w;
    logic [DW:0] mon_e;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_word", 64'({m_last, m_data}), 64'(prev_w));
            end
            if (m_valid && m_ready) begin
                check("abort_low", 64'(m_abort), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'd0, 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_word", 64'({m_last, m_data}), 64'(mon_e));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_w     = {m_last, m_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation budget exhausted");
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        int i;
        int guard;
        bit v;
        bit a;

        // Reset values
        tick();
        tick();
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", 64'(m_data), 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_drops", 64'(drops), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_abort", 64'(m_abort), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic pass-through and latency
        m_ready = 1'b1;
        send_pkt(4, 32'h11);
        check("lat_n1_valid", 64'(m_valid), 64'd0);
        tick();
        check("lat_n2_valid", 64'(m_valid), 64'd1);
        check("lat_n2_data", 64'(m_data), 64'h11);
        drain("basic_drain");
        check("basic_drops", 64'(drops), 64'(drops_exp()));

        // Abort without VALID
        send(1'b1, 32'hA0, 1'b0, 1'b0);
        send(1'b1, 32'hA1, 1'b0, 1'b0);
        send(1'b1, 32'hA2, 1'b0, 1'b0);
        send(1'b0, 32'h0, 1'b0, 1'b1);
        check("abort_state", 64'(dbg_state), 64'd0);
        send_pkt(2, 32'hB0);
        drain("abort_drain");
        check("abort_drops", 64'(drops), 64'(drops_exp()));

        // Overflow
        m_ready = 1'b0;
        for (int k = 0; k < 20; k++) send(1'b1, 32'h100 + 32'(k), k == 19, 1'b0);
        tick();
        check("ovf_fill0", 64'(fill), 64'd0);
        check("ovf_valid0", 64'(m_valid), 64'd0);
        check("ovf_drops", 64'(drops), 64'(drops_exp()));
        send_pkt(16, 32'h200);
        tick();
        check("ovf_fill16", 64'(fill), 64'd16);
        m_ready = 1'b1;
        drain("ovf_drain");
        tick();
        tick();
        check("ovf_fill_end", 64'(fill), 64'd0);

        // Back-pressure with READY toggling
        toggle_rdy = 1'b1;
        send_pkt(1, 32'h300);
        send_pkt(5, 32'h310);
        send_pkt(3, 32'h320);
        drain("bp_drain");
        toggle_rdy = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        check("bp_fill", 64'(fill), 64'd0);

        // Abort coincident with LAST
        send(1'b1, 32'h400, 1'b0, 1'b0);
        send(1'b1, 32'h401, 1'b0, 1'b0);
        send(1'b1, 32'h402, 1'b1, 1'b1);
        check("abl_state", 64'(dbg_state), 64'd0);
        check("abl_drops", 64'(drops), 64'(drops_exp()));
        send_pkt(2, 32'h410);
        drain("abl_drain");

        // Reset mid-operation
        m_ready = 1'b0;
        send_pkt(2, 32'h500);
        send_pkt(3, 32'h510);
        send(1'b1, 32'h520, 1'b0, 1'b0);
        send(1'b1, 32'h521, 1'b0, 1'b0);
        tick();
        tick();
        check("pre_rst_valid", 64'(m_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(m_valid), 64'd0);
        check("mid_rst_fill", 64'(fill), 64'd0);
        check("mid_rst_drops", 64'(drops), 64'd0);
        exp_q.delete();
        pkt_q.delete();
        dropping = 1'b0;
        model_drops = 0;
        tick();
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick();
        send_pkt(2, 32'h600);
        drain("rst_drain");

        // Randomized packets with aborts, gaps and random READY
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 6);
            guard = 0;
            while (exp_q.size() + len > DEPTH && guard < 100) begin
                m_ready = 1'b1;
                send(1'b0, '0, 1'b0, 1'b0);
                guard++;
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) send(1'b0, '0, 1'b0, 1'b0);
            i = 0;
            while (i < len) begin
                m_ready = ($urandom_range(0, 3) != 0);
                v = ($urandom_range(0, 4) != 0);
                a = ($urandom_range(0, 15) == 0);
                send(v, $urandom, v && (i == len - 1), a);
                if (a) break;
                if (v) i++;
            end
            check("rand_drops", 64'(drops), 64'(drops_exp()));
        end
        m_ready = 1'b1;
        drain("rand_drain");
        tick();
        tick();
        check("rand_fill", 64'(fill), 64'd0);
        check("rand_state", 64'(dbg_state), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/netrxfifo.md
# netrxfifo

Store-and-forward packet FIFO at the receiving end of the abortable network stream. Accepts words with VALID/LAST/ABORT and never back-pressures its source. Aborted and overflowing packets are rolled back so they never reach the output. Emits only complete packets on an output stream whose ABORT is permanently low, for consumers that cannot handle mid-packet aborts.

## Interface

Parameters:
- DW, 32, data word width
- LGFLEN, 10, log2 of buffer depth in words (depth = 2^LGFLEN)

Ports:
- i_clk  in  1  clock; everything is on its rising edge
- i_reset_n  in  1  reset, asynchronous assert, active low
- S_AXIN_VALID  in  1  input word valid
- S_AXIN_READY  out  1  constant 1
- S_AXIN_DATA  in  DW  input word
- S_AXIN_LAST  in  1  final word of packet
- S_AXIN_ABORT  in  1  discard current packet; meaningful with or without VALID
- M_AXIN_VALID  out  1  output word valid
- M_AXIN_READY  in  1  downstream accepts
- M_AXIN_DATA  out  DW  output word
- M_AXIN_LAST  out  1  final word of packet
- M_AXIN_ABORT  out  1  constant 0
- o_fill  out  LGFLEN+1  committed words held, excluding the output register
- o_drops  out  16  dropped-packet count (see Configuration)

## Operation

- Storage: 2^LGFLEN entries of {LAST, DATA}, one write port and one read port.
- Pointers are LGFLEN+1 bits wide and wrap naturally:
  - wr_ptr: speculative write position
  - wr_commit: end of the last complete packet
  - rd_ptr: next entry to read
- Arithmetic is modulo 2^(LGFLEN+1). Buffer is full when wr_ptr − rd_ptr == 2^LGFLEN.
- Input FSM states are IDLE, WRITE and DROP.
  - IDLE/WRITE, word accepted with ABORT low:
    - If the buffer is full, roll back wr_ptr to wr_commit, count a drop, and go to DROP. If that word has LAST, go to IDLE instead.
    - Otherwise write the word and increment wr_ptr.
    - If the word has LAST, set wr_commit to the new wr_ptr and go to IDLE. Otherwise go to WRITE.
  - WRITE, S_AXIN_ABORT high (VALID ignored): roll back wr_ptr to wr_commit, count a drop, go to IDLE.
  - IDLE, ABORT high without a valid word: ignored; nothing is counted.
  - IDLE, ABORT high together with a valid word: the word is discarded and a drop is counted.
  - DROP: discard every word. Leave to IDLE on an accepted LAST or on ABORT. Nothing further is counted.
- ABORT takes precedence over LAST in the same cycle: the packet is dropped.
- Output side:
  - A one-entry output register loads from memory when wr_commit != rd_ptr and the register is empty or being accepted (M_AXIN_VALID && M_AXIN_READY). rd_ptr increments on each load.
  - Data and LAST are held stable while VALID is high and READY is low.
- o_fill = wr_commit − rd_ptr, registered.
- Committing and reading in the same cycle are independent; both take effect.

## Timing

- Reset values:
  - wr_ptr = wr_commit = rd_ptr = 0; FSM = IDLE.
  - M_AXIN_VALID = 0, M_AXIN_LAST = 0, M_AXIN_DATA = 0.
  - o_fill = 0, o_drops = 0.
  - S_AXIN_READY = 1; M_AXIN_ABORT = 0.
- Reset mid-packet discards all buffered and partial data. After release the input is treated as being at a packet boundary.
- Latency, with the output empty and READY high:
  - LAST accepted in cycle N.
  - wr_commit updated at edge N+1.
  - First word has M_AXIN_VALID high in cycle N+2.
- Throughput is one word per clock in each direction.
- A rollback takes effect at the clock edge that samples ABORT, so a new packet may begin on the very next cycle.

## Configuration

- Macro: NETRXFIFO_DROPCOUNT_EN.
- Defined:
  - o_drops is a 16-bit counter that saturates at 0xFFFF.
  - It increments by 1 per dropped packet, whether the drop is due to abort or overflow.
  - It is reset to 0.
- Undefined: o_drops is tied to 0 and no counter logic is synthesized.

## Test plan

- Basic pass-through: send 4-word packet 0x11,0x12,0x13,0x14 (LAST on 0x14), M_AXIN_READY=1 → identical words out, LAST only on 0x14, first VALID two cycles after LAST is accepted, ABORT never high, o_drops=0.
- Abort without VALID: send words 0xA0,0xA1,0xA2, then ABORT with VALID low, then packet 0xB0,0xB1 → output is only 0xB0,0xB1; o_drops=1 (0 if macro undefined).
- Overflow: LGFLEN=4, M_AXIN_READY=0, send a 20-word packet → o_fill stays 0, o_drops=1. Then send a 16-word packet → o_fill=16. Raise READY → exactly those 16 words come out.
- Back-pressure: three packets of lengths 1, 5 and 3, M_AXIN_READY toggling 1,0,1,0 → all 9 words in order, DATA/LAST stable during stalls, o_fill returns to 0.
- Abort coincident with LAST: 3-word packet with ABORT high on the LAST beat → nothing output, o_drops=1, FSM back in IDLE. The next packet passes intact.
- Reset mid-operation: assert i_reset_n low while 2 committed packets are queued and a third is partly written → M_AXIN_VALID=0 and o_fill=0 immediately. After release, a fresh 2-word packet passes unaltered.
